// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size and FSM state encodings,
// plus lane helpers that the CPU decoder also reuses.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsuSize_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsuState_t;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_HALF: isMisaligned = lane[0];
      SZ_WORD: isMisaligned = |lane;
      default: isMisaligned = 1'b0;
    endcase
  endfunction

  // One bit per byte of the word that an access of this size/lane touches.
  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: laneMask = 4'b0001 << lane;
      SZ_HALF: laneMask = lane[1] ? 4'b1100 : 4'b0011;
      default: laneMask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory port of the load/store unit, bundled so the
// unit (slave) and the datapath/memory side (master) share one connection.
interface load_store_unit_if;
  // Request: taken on a rising edge where ReqValid && ReqReady; the Req* fields only need
  // to be stable in that cycle. Response: RespValid is a single-cycle pulse with no
  // backpressure, RespData/RespErr are only meaningful while it is high.
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWrData;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespErr;
  logic [31:0] DmemAddr;
  logic        DmemWrite;
  logic [31:0] DmemWrData;
  logic [31:0] DmemRdData;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWrData, DmemRdData,
    output ReqReady, RespValid, RespData, RespErr, DmemAddr, DmemWrite, DmemWrData
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWrData, DmemRdData,
    input  ReqReady, RespValid, RespData, RespErr, DmemAddr, DmemWrite, DmemWrData
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: extracts and sign/zero-extends load data, and merges
// sub-word store data into a previously read word.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [1:0]  lane,
  input  logic [31:0] rdWord,
  input  logic [31:0] keepWord,
  input  logic [31:0] stData,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] stRep;
  logic [3:0]  mask;

  always_comb begin
    byteSel = rdWord[{lane, 3'b000} +: 8];
    halfSel = lane[1] ? rdWord[31:16] : rdWord[15:0];
    case (size)
      SZ_BYTE: loadData = {{24{signExt & byteSel[7]}}, byteSel};
      SZ_HALF: loadData = {{16{signExt & halfSel[15]}}, halfSel};
      default: loadData = rdWord;
    endcase
  end

  // Replicate the store data across all lanes, then let the mask pick which bytes land.
  always_comb begin
    case (size)
      SZ_BYTE: stRep = {4{stData[7:0]}};
      SZ_HALF: stRep = {2{stData[15:0]}};
      default: stRep = stData;
    endcase
    mask = laneMask(size, lane);
    for (int i = 0; i < 4; i++) begin
      mergedWord[8*i +: 8] = mask[i] ? stRep[8*i +: 8] : keepWord[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-addressed data memory from byte/half/word CPU requests,
// using read-modify-write for sub-word stores. Define LSU_BOUNDS_CHECK_EN to reject
// addresses above the memory range instead of wrapping them.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DMEM_AW = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  load_store_unit_if.slave  bus,
  output lsuState_t         DbgState
);

  lsuState_t   state, stateNxt;
  logic        reqWriteQ;
  logic [1:0]  reqSizeQ;
  logic        reqSignedQ;
  logic [1:0]  laneQ;
  logic [31:0] wrDataQ;
  logic [31:0] rdWordQ;
  logic [31:0] respDataQ;
  logic        respErrQ;
  logic [31:0] dmemAddrQ;
  logic        accept;
  logic        boundsErr;
  logic        reqErr;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

`ifdef LSU_BOUNDS_CHECK_EN
  assign boundsErr = |bus.ReqAddr[31:DMEM_AW+2];
`else
  // Upper address bits are intentionally dropped: accesses wrap within the memory.
  logic unusedAddrHi;
  assign unusedAddrHi = ^bus.ReqAddr[31:DMEM_AW+2];
  assign boundsErr    = 1'b0;
`endif

  assign accept = bus.ReqValid && (state == IDLE);
  assign reqErr = (bus.ReqSize == SZ_ILL) || isMisaligned(bus.ReqSize, bus.ReqAddr[1:0]) ||
                  boundsErr;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (bus.ReqValid) begin
          if (reqErr)                    stateNxt = RESP;
          else if (!bus.ReqWrite)        stateNxt = RD;
          else if (bus.ReqSize == SZ_WORD) stateNxt = WR;
          else                           stateNxt = RD;
        end
      end
      RD:      stateNxt = reqWriteQ ? WR : RESP;
      WR:      stateNxt = RESP;
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      reqWriteQ  <= 1'b0;
      reqSizeQ   <= 2'b00;
      reqSignedQ <= 1'b0;
      laneQ      <= 2'b00;
      wrDataQ    <= '0;
      rdWordQ    <= '0;
      respDataQ  <= '0;
      respErrQ   <= 1'b0;
      dmemAddrQ  <= '0;
    end else if (accept) begin
      reqWriteQ  <= bus.ReqWrite;
      reqSizeQ   <= bus.ReqSize;
      reqSignedQ <= bus.ReqSigned;
      laneQ      <= bus.ReqAddr[1:0];
      wrDataQ    <= bus.ReqWrData;
      respDataQ  <= '0;
      respErrQ   <= reqErr;
      dmemAddrQ  <= {{(32-DMEM_AW){1'b0}}, bus.ReqAddr[DMEM_AW+1:2]};
    end else if (state == RD) begin
      // A load finishes its extraction here; a sub-word store keeps the word for merging.
      if (reqWriteQ) rdWordQ   <= bus.DmemRdData;
      else           respDataQ <= loadData;
    end
  end

  load_store_unit_align u_align (
    .size       (reqSizeQ),
    .signExt    (reqSignedQ),
    .lane       (laneQ),
    .rdWord     (bus.DmemRdData),
    .keepWord   (rdWordQ),
    .stData     (wrDataQ),
    .loadData   (loadData),
    .mergedWord (mergedWord)
  );

  // Memory-side and response outputs are pure decodes of state so a reset drops them at once.
  assign bus.ReqReady   = (state == IDLE);
  assign bus.DmemWrite  = (state == WR);
  assign bus.DmemWrData = (state == WR) ? mergedWord : '0;
  assign bus.DmemAddr   = dmemAddrQ;
  assign bus.RespValid  = (state == RESP);
  assign bus.RespData   = (state == RESP) ? respDataQ : '0;
  assign bus.RespErr    = (state == RESP) && respErrQ;
  assign DbgState       = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort sequences, and random
// traffic checked against a word-array reference model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int DMEM_AW = 8;
  localparam int DEPTH   = 1 << DMEM_AW;

  logic      Clk   = 1'b0;
  logic      Rst_n = 1'b0;
  lsuState_t dbgState;

  load_store_unit_if bus ();

  load_store_unit #(.DMEM_AW(DMEM_AW)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .bus      (bus),
    .DbgState (dbgState)
  );

  always #5 Clk = ~Clk;

  // Data memory: combinational read returning 0 during writes, plus a backdoor for preload.
  logic [31:0]        mem    [DEPTH];
  logic [31:0]        refMem [DEPTH];
  logic               bdEn  = 1'b0;
  logic [DMEM_AW-1:0] bdIdx = '0;
  logic [31:0]        bdVal = '0;

  assign bus.DmemRdData = bus.DmemWrite ? 32'h0 : mem[bus.DmemAddr[DMEM_AW-1:0]];

  always @(posedge Clk) begin
    if (bdEn)               mem[bdIdx] <= bdVal;
    else if (bus.DmemWrite) mem[bus.DmemAddr[DMEM_AW-1:0]] <= bus.DmemWrData;
  end

  int total = 0;
  int bad   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check32({tag, "_ready"},    32'(bus.ReqReady),   32'd1);
    check32({tag, "_rvalid"},   32'(bus.RespValid),  32'd0);
    check32({tag, "_rdata"},    bus.RespData,        32'd0);
    check32({tag, "_rerr"},     32'(bus.RespErr),    32'd0);
    check32({tag, "_daddr"},    bus.DmemAddr,        32'd0);
    check32({tag, "_dwrite"},   32'(bus.DmemWrite),  32'd0);
    check32({tag, "_dwrdata"},  bus.DmemWrData,      32'd0);
    check32({tag, "_state"},    32'(dbgState),       32'(IDLE));
  endtask

  task automatic bdWrite(input int idx, input logic [31:0] val);
    @(negedge Clk);
    bdEn  = 1'b1;
    bdIdx = idx[DMEM_AW-1:0];
    bdVal = val;
    refMem[idx] = val;
    @(posedge Clk);
    #1 bdEn = 1'b0;
  endtask

  task automatic driveReq(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd);
    bus.ReqValid  = 1'b1;
    bus.ReqWrite  = w;
    bus.ReqSize   = sz;
    bus.ReqSigned = sg;
    bus.ReqAddr   = addr;
    bus.ReqWrData = wd;
  endtask

  task automatic idleReq();
    bus.ReqValid  = 1'b0;
    bus.ReqWrite  = $urandom_range(0, 1);
    bus.ReqSize   = 2'($urandom_range(0, 3));
    bus.ReqAddr   = $urandom;
    bus.ReqWrData = $urandom;
  endtask

  // Issue one request and watch it to completion; lat=-1 means no response in budget.
  task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rData, output logic rErr, output int lat,
                       output int nWr, output logic [31:0] rAddr);
    int guard;
    @(negedge Clk);
    guard = 0;
    while (!bus.ReqReady && guard < 10) begin
      @(negedge Clk);
      guard++;
    end
    check32("ready_before_req", 32'(bus.ReqReady), 32'd1);
    driveReq(w, sz, sg, addr, wd);
    @(posedge Clk);
    #1 idleReq();
    lat   = -1;
    nWr   = 0;
    rData = 'x;
    rErr  = 1'bx;
    rAddr = 'x;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      if (bus.DmemWrite) nWr++;
      if (bus.RespValid) begin
        lat   = i;
        rData = bus.RespData;
        rErr  = bus.RespErr;
        rAddr = bus.DmemAddr;
        break;
      end
    end
  endtask

  // Reference model: words as plain integers, lanes by shift/mask arithmetic.
  task automatic refStep(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] eData, output logic eErr, output int eLat,
                         output int eWr, output logic [31:0] eAddr);
    int          idx, off, nbits;
    logic [31:0] mask, val;
    idx   = int'((addr / 4) % DEPTH);
    off   = int'(addr % 4);
    eAddr = 32'(idx);
    eErr  = (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    if (addr >= 32'(4 * DEPTH)) eErr = 1'b1;
`endif
    eData = 32'h0;
    if (eErr) begin
      eLat = 1;
      eWr  = 0;
      return;
    end
    nbits = 8 << sz;
    mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'h1 << nbits) - 32'h1);
    if (!w) begin
      val = (refMem[idx] >> (8 * off)) & mask;
      if (sg && nbits < 32 && val[nbits-1]) val = val | ~mask;
      eData = val;
      eLat  = 2;
      eWr   = 0;
    end else begin
      refMem[idx] = (refMem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      eLat = (nbits == 32) ? 2 : 3;
      eWr  = 1;
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] expData;
    logic        expErr;
    int          expLat;
    int          expWr;
    int          memIdx;
    logic [31:0] memVal;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rData, eData, rAddr, eAddr;
    logic        rErr, eErr;
    int          lat, eLat, nWr, eWr, memBad;

    vecs[0]  = '{1'b0, 2'd0, 1'b1, 32'h0F, 32'h0,         32'hFFFF_FF88, 1'b0, 2, 0, -1, 32'h0};
    vecs[1]  = '{1'b0, 2'd1, 1'b0, 32'h0C, 32'h0,         32'h0000_AABB, 1'b0, 2, 0, -1, 32'h0};
    vecs[2]  = '{1'b0, 2'd1, 1'b1, 32'h0E, 32'h0,         32'hFFFF_8899, 1'b0, 2, 0, -1, 32'h0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0D, 32'h0,         32'h0000_00AA, 1'b0, 2, 0, -1, 32'h0};
    vecs[4]  = '{1'b0, 2'd2, 1'b1, 32'h0C, 32'h0,         32'h8899_AABB, 1'b0, 2, 0, -1, 32'h0};
    vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h16, 32'hFFFF_FFEE, 32'h0,         1'b0, 3, 1, 5, 32'h11EE_3344};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h14, 32'hABCD_1234, 32'h0,         1'b0, 3, 1, 5, 32'h11EE_1234};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_BEEF, 32'h0,         1'b0, 3, 1, 5, 32'hBEEF_1234};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h12, 32'hDEAD_BEEF, 32'h0,         1'b1, 1, 0, 4, 32'h0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h0D, 32'h0,         32'h0,         1'b1, 1, 0, -1, 32'h0};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h0C, 32'h0,         32'h0,         1'b1, 1, 0, -1, 32'h0};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h18, 32'h5555_AAAA, 32'h0,         1'b0, 2, 1, 6, 32'h5555_AAAA};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h18, 32'h0,         32'hFFFF_FFAA, 1'b0, 2, 0, -1, 32'h0};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h1B, 32'h0,         32'h0000_0055, 1'b0, 2, 0, -1, 32'h0};
`ifdef LSU_BOUNDS_CHECK_EN
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h0,         1'b1, 1, 0, -1, 32'h0};
`else
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h0102_0304, 1'b0, 2, 0, -1, 32'h0};
`endif

    // Clock/reset
    idleReq();
    bus.ReqSigned = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    checkResetOutputs("after_release");

    // Preload memory
    for (int i = 0; i < DEPTH; i++) bdWrite(i, $urandom);
    bdWrite(0, 32'h0102_0304);
    bdWrite(3, 32'h8899_AABB);
    bdWrite(4, 32'h0);
    bdWrite(5, 32'h1122_3344);
    bdWrite(6, 32'h0);
    bdWrite(8, 32'hCAFE_F00D);

    // Directed vectors
    for (int v = 0; v < 15; v++) begin
      doReq(vecs[v].w, vecs[v].sz, vecs[v].sg, vecs[v].addr, vecs[v].wd,
            rData, rErr, lat, nWr, rAddr);
      refStep(vecs[v].w, vecs[v].sz, vecs[v].sg, vecs[v].addr, vecs[v].wd,
              eData, eErr, eLat, eWr, eAddr);
      check32($sformatf("vec%0d_data", v), rData, vecs[v].expData);
      check32($sformatf("vec%0d_err", v), 32'(rErr), 32'(vecs[v].expErr));
      checkInt($sformatf("vec%0d_latency", v), lat, vecs[v].expLat);
      checkInt($sformatf("vec%0d_writes", v), nWr, vecs[v].expWr);
      check32($sformatf("vec%0d_dmemaddr", v), rAddr, eAddr);
      if (vecs[v].memIdx >= 0)
        check32($sformatf("vec%0d_mem", v), mem[vecs[v].memIdx], vecs[v].memVal);
    end

    // Reset during the WR cycle of a word store
    @(negedge Clk);
    driveReq(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678);
    @(posedge Clk);
    #1 idleReq();
    @(negedge Clk);
    check32("abort_wr_inflight", 32'(bus.DmemWrite), 32'd1);
    Rst_n = 1'b0;
    #1 checkResetOutputs("abort_wr");
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check32("abort_wr_mem8", mem[8], 32'hCAFE_F00D);
    checkResetOutputs("abort_wr_release");

    // Reset during the RD cycle of a sub-word store
    driveReq(1'b1, 2'd0, 1'b0, 32'h21, 32'h55);
    @(posedge Clk);
    #1 idleReq();
    @(negedge Clk);
    check32("abort_rd_state", 32'(dbgState), 32'(RD));
    Rst_n = 1'b0;
    #1 checkResetOutputs("abort_rd");
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    nWr = 0;
    lat = 0;
    repeat (4) begin
      @(negedge Clk);
      if (bus.DmemWrite) nWr++;
      if (bus.RespValid) lat++;
    end
    checkInt("abort_rd_writes", nWr, 0);
    checkInt("abort_rd_resp", lat, 0);
    check32("abort_rd_mem8", mem[8], 32'hCAFE_F00D);

    // Random traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      logic        w, sg;
      logic [1:0]  sz;
      logic [31:0] addr, wd;
      w    = $urandom_range(0, 1);
      sz   = 2'($urandom_range(0, 3));
      sg   = $urandom_range(0, 1);
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
      wd   = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'd0) addr = addr & ~((32'h1 << sz) - 32'h1);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      doReq(w, sz, sg, addr, wd, rData, rErr, lat, nWr, rAddr);
      refStep(w, sz, sg, addr, wd, eData, eErr, eLat, eWr, eAddr);
      check32($sformatf("rnd%0d_data a=%h", n, addr), rData, eData);
      check32($sformatf("rnd%0d_err a=%h", n, addr), 32'(rErr), 32'(eErr));
      checkInt($sformatf("rnd%0d_latency", n), lat, eLat);
      checkInt($sformatf("rnd%0d_writes", n), nWr, eWr);
      check32($sformatf("rnd%0d_dmemaddr", n), rAddr, eAddr);
    end

    @(negedge Clk);
    memBad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== refMem[i]) begin
        if (memBad < 4) $display("note: word %0d got %h want %h", i, mem[i], refMem[i]);
        memBad++;
      end
    end
    checkInt("final_mem_mismatch_words", memBad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
